// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared readout state, reset constants and byte-count helper
package product_accumulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  localparam rd_state_t  RST_STATE   = IDLE;
  localparam logic [7:0] RST_RD_DATA = 8'h00;
  localparam logic       RST_SAT     = 1'b0;

  function automatic int nbytes(input int acc_w);
    return acc_w / 8;
  endfunction

endpackage

// File: rtl/product_accumulator_acc_byte_serializer.sv
// rtl/product_accumulator_acc_byte_serializer.sv - snapshots a word and streams it LSB-first as bytes
module acc_byte_serializer
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [ACC_W-1:0] word,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             busy
);

  localparam int NBYTES = nbytes(ACC_W);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [ACC_W-1:0] shadow;
  logic [IDX_W-1:0] idx;
  logic             last_byte;

  assign last_byte = (idx == IDX_W'(NBYTES - 1));

  // Shadow is written only on the IDLE->SEND transition so it stays frozen for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST_STATE;
      shadow <= '0;
      idx    <= '0;
    end else if (ena) begin
      state <= state_nxt;
      if (state == IDLE && load) begin
        shadow <= word;
        idx    <= '0;
      end else if (state == SEND && rd_ready && !last_byte) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SEND;
      SEND:    if (rd_ready && last_byte) state_nxt = IDLE;
      default: state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    busy     = 1'b0;
    rd_data  = RST_RD_DATA;
    if (state == SEND) begin
      rd_valid = 1'b1;
      busy     = 1'b1;
      rd_last  = last_byte;
      rd_data  = shadow[{idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating product accumulator with counter and byte readout
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         prod,
  input  logic               prod_valid,
  input  logic               acc_clear,
  input  logic               rd_req,
  input  logic               rd_ready,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               busy,
  output logic               sat,
  output logic [COUNT_W-1:0] count
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             count_full;

  assign sum        = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};
  assign count_full = &count;

  // Clear takes priority; a product arriving with the clear becomes the first term of the new sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      sat   <= RST_SAT;
    end else if (ena) begin
      if (acc_clear) begin
        sat <= 1'b0;
        if (prod_valid) begin
          acc   <= {{(ACC_W - 8){1'b0}}, prod};
          count <= COUNT_W'(1);
        end else begin
          acc   <= '0;
          count <= '0;
        end
      end else if (prod_valid) begin
        if (sum[ACC_W]) begin
          acc <= '1;
          sat <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
        if (!count_full) count <= count + 1'b1;
      end
    end
  end

  // The serializer sees the pre-update accumulator, so read-and-clear returns the old value.
  acc_byte_serializer #(
    .ACC_W (ACC_W)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (rd_req),
    .word     (acc),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .busy     (busy)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed and randomized bench for product_accumulator
module tb_product_accumulator;

  localparam int NB      = 2;
  localparam int ACC_MAX = 65535;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] prod;
  logic       prod_valid;
  logic       acc_clear;
  logic       rd_req;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       busy;
  logic       sat;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  int         m_acc;
  int         m_count;
  bit         m_sat;
  logic [7:0] m_q[$];

  product_accumulator #(.ACC_W(16), .COUNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .prod       (prod),
    .prod_valid (prod_valid),
    .acc_clear  (acc_clear),
    .rd_req     (rd_req),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .busy       (busy),
    .sat        (sat),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_count = 0;
    m_sat   = 0;
    m_q.delete();
  endtask

  // One clock of the specified behaviour, evaluated from the inputs present before the edge.
  task automatic model_step();
    bit was_busy;
    int pre_acc;
    if (!ena) return;
    was_busy = (m_q.size() != 0);
    pre_acc  = m_acc;
    if (was_busy && rd_ready) void'(m_q.pop_front());
    if (!was_busy && rd_req)
      for (int i = 0; i < NB; i++) m_q.push_back(8'((pre_acc >> (8 * i)) & 255));
    if (acc_clear) begin
      m_acc   = prod_valid ? int'(prod) : 0;
      m_count = prod_valid ? 1 : 0;
      m_sat   = 0;
    end else if (prod_valid) begin
      if (m_acc + int'(prod) > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_sat = 1;
      end else begin
        m_acc = m_acc + int'(prod);
      end
      if (m_count < CNT_MAX) m_count++;
    end
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, (m_q.size() != 0));
    chk("busy", busy, (m_q.size() != 0));
    chk("sat", sat, m_sat);
    chk("count", count, m_count);
    if (m_q.size() != 0) begin
      chk("rd_data", rd_data, m_q[0]);
      chk("rd_last", rd_last, (m_q.size() == 1));
    end
  endtask

  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; prod = 8'h00; prod_valid = 1'b0;
    acc_clear = 1'b0; rd_req = 1'b0; rd_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_last", rd_last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sat", sat, 1'b0);
    chk("reset_count", count, 8'h00);
    rst_n = 1'b1;

    // Three products then a full readout
    prod_valid = 1'b1;
    prod = 8'hE1; cycle();
    prod = 8'h10; cycle();
    prod = 8'h05; cycle();
    prod_valid = 1'b0; rd_req = 1'b1; rd_ready = 1'b1;
    cycle();
    chk("t1_b0", rd_data, 8'hF6); chk("t1_last0", rd_last, 1'b0);
    rd_req = 1'b0;
    cycle();
    chk("t1_b1", rd_data, 8'h00); chk("t1_last1", rd_last, 1'b1);
    cycle();
    chk("t1_idle", busy, 1'b0); chk("t1_count", count, 8'd3); chk("t1_sat", sat, 1'b0);

    // Saturation
    acc_clear = 1'b1; cycle(); acc_clear = 1'b0;
    prod_valid = 1'b1; prod = 8'hE1;
    for (int i = 1; i <= 300; i++) begin
      cycle();
      chk("t2_sat", sat, (i >= 292));
    end
    chk("t2_count", count, 8'hFF);
    prod_valid = 1'b0; rd_req = 1'b1; rd_ready = 1'b1;
    cycle(); chk("t2_b0", rd_data, 8'hFF);
    rd_req = 1'b0;
    cycle(); chk("t2_b1", rd_data, 8'hFF); chk("t2_last", rd_last, 1'b1);
    cycle();

    // Read-and-clear with a product in the same cycle
    acc_clear = 1'b1; prod_valid = 1'b1; prod = 8'h80; cycle();
    acc_clear = 1'b0; cycle();
    rd_req = 1'b1; acc_clear = 1'b1; prod = 8'h21; rd_ready = 1'b1;
    cycle();
    chk("t3_b0", rd_data, 8'h00); chk("t3_count", count, 8'd1); chk("t3_sat", sat, 1'b0);
    rd_req = 1'b0; acc_clear = 1'b0; prod_valid = 1'b0;
    cycle(); chk("t3_b1", rd_data, 8'h01); chk("t3_last", rd_last, 1'b1);
    cycle();
    rd_req = 1'b1; cycle(); chk("t3_acc_lo", rd_data, 8'h21);
    rd_req = 1'b0; cycle(); chk("t3_acc_hi", rd_data, 8'h00);
    cycle();

    // Back-pressure on byte 0 and an ignored rd_req during SEND
    rd_ready = 1'b0; rd_req = 1'b1; cycle();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_req = (i == 1);
      cycle();
      chk("t4_hold_data", rd_data, 8'h21);
      chk("t4_hold_last", rd_last, 1'b0);
    end
    rd_req = 1'b0; rd_ready = 1'b1;
    cycle(); chk("t4_adv", rd_data, 8'h00); chk("t4_adv_last", rd_last, 1'b1);
    cycle(); chk("t4_done", busy, 1'b0);

    // Asynchronous reset mid-readout
    prod_valid = 1'b1; prod = 8'h5A; cycle();
    prod_valid = 1'b0; rd_req = 1'b1; cycle();
    rd_req = 1'b0; cycle();
    rst_n = 1'b0; #1;
    model_reset();
    chk("t5_valid", rd_valid, 1'b0); chk("t5_busy", busy, 1'b0); chk("t5_count", count, 8'h00);
    cycle(); cycle();
    rst_n = 1'b1;
    rd_req = 1'b1; cycle(); chk("t5_b0", rd_data, 8'h00);
    rd_req = 1'b0; cycle(); chk("t5_b1", rd_data, 8'h00);
    cycle();

    // Enable low freezes accumulation and readout
    prod_valid = 1'b1; prod = 8'h30; cycle();
    prod_valid = 1'b0; rd_req = 1'b1; rd_ready = 1'b1; cycle();
    rd_req = 1'b0; ena = 1'b0; prod_valid = 1'b1; prod = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t6_data", rd_data, 8'h30); chk("t6_count", count, 8'd1); chk("t6_valid", rd_valid, 1'b1);
    end
    ena = 1'b1;
    cycle(); chk("t6_b1", rd_data, 8'h00); chk("t6_last", rd_last, 1'b1); chk("t6_count2", count, 8'd2);
    prod_valid = 1'b0; cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ena        = ($urandom_range(0, 9) != 0);
      prod       = 8'($urandom);
      prod_valid = ($urandom_range(0, 9) < 7);
      acc_clear  = ($urandom_range(0, 199) == 0);
      rd_req     = ($urandom_range(0, 9) == 0);
      rd_ready   = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 4x4 array multiplier. Takes each 8-bit product it is given, sums it into a saturating accumulator, and counts the accepted products. On request it snapshots the sum and streams it out LSB-first as bytes over a valid/ready handshake. It sits between the combinational multiplier output and the chip's byte-wide I/O path.

## Interface
- ACC_W, 16, accumulator width in bits; must be a multiple of 8 and at least 16.
- COUNT_W, 8, width of the accepted-product counter.
- NBYTES, ACC_W/8, derived; number of bytes per readout.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; when low, all registers hold.
- prod  in  8  product from the multiplier, unsigned.
- prod_valid  in  1  prod is accepted this cycle.
- acc_clear  in  1  zero the accumulator, count and sat.
- rd_req  in  1  single-cycle pulse that starts a readout.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  8  current readout byte.
- rd_valid  out  1  rd_data is valid.
- rd_last  out  1  current byte is the final byte (byte NBYTES-1).
- busy  out  1  readout in progress.
- sat  out  1  sticky flag: the accumulator has clipped.
- count  out  COUNT_W  number of products accepted since the last clear.

## Operation
- **Reset values.** acc=0, count=0, sat=0, shadow=0, state=IDLE; rd_data=0, rd_valid=0, rd_last=0, busy=0.
- **Accumulate** (ena=1, prod_valid=1, acc_clear=0):
  - acc <= acc + zero-extended prod, computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W-1: acc <= all-ones and sat <= 1.
  - count increments and saturates at all-ones; it never wraps.
- **Clear, no product** (acc_clear=1, prod_valid=0): acc, count and sat go to 0.
- **Clear with product** (acc_clear=1, prod_valid=1): acc <= prod, count <= 1, sat <= 0.
- **Readout FSM states:** IDLE, SEND.
  - IDLE: on rd_req=1, shadow <= acc value before this cycle's update, idx <= 0, go to SEND.
  - SEND: rd_valid=1, rd_data=shadow[8*idx +: 8], rd_last=(idx==NBYTES-1), busy=1.
  - SEND: on rd_ready=1 with idx<NBYTES-1, idx increments.
  - SEND: on rd_ready=1 with rd_last=1, return to IDLE.
- rd_req while busy is ignored.
- Accumulation and clear keep running during SEND. The shadow register is never disturbed once captured.
- rd_req together with acc_clear in the same cycle is read-and-clear: the pre-clear value is read out.
- ena=0: FSM, acc, count and shadow all hold; outputs remain stable.
- rst_n asserted mid-readout: immediate return to the reset values above; the partial transfer is abandoned.

## Timing
- rd_req sampled at edge N: rd_valid=1 with byte 0 from N+1.
- One byte per cycle while rd_ready=1. A full readout with rd_ready held high takes NBYTES cycles; busy falls on the edge after the last accept.
- While rd_valid=1 and rd_ready=0, rd_data and rd_last are held stable.
- Earliest next rd_req is accepted in the first cycle back in IDLE.
- Accumulate latency: product accepted at edge N appears in acc and count after edge N.
- Outputs rd_data, rd_valid, rd_last and busy are registered or decoded from registers only; no combinational path from prod.

## Structure
- Shared package: readout state enum (IDLE, SEND), reset constants, and an NBYTES helper function.
- Sub-module acc_byte_serializer owns shadow, idx and the handshake. It takes a load pulse plus an ACC_W-bit word and produces rd_*/busy.
- The top level holds the saturating adder, counter and sat flag.

## Test plan
- Reset, then accept prods 0xE1, 0x10, 0x05, then rd_req with rd_ready=1 -> bytes 0xF6 (rd_last=0), then 0x00 (rd_last=1); count=3, sat=0.
- 300 consecutive prod=0xE1 -> acc=0xFFFF, sat=1 from the 292nd product, count=0xFF; readout gives 0xFF, 0xFF.
- Accumulator at 0x0100: assert rd_req, acc_clear and prod_valid (prod=0x21) together -> readout 0x00, 0x01; acc=0x0021, count=1.
- Readout with rd_ready low for 3 cycles on byte 0 -> rd_data=byte 0 held stable; advances on the first rd_ready=1; a second rd_req during SEND has no effect.
- rst_n low after byte 0 accepted -> rd_valid, busy, acc and count read 0 immediately; a fresh rd_req after release reads 0x00, 0x00.
- ena=0 for 4 cycles with prod_valid=1 and rd_ready=1 during SEND -> no accumulation and no byte advance; resumes exactly when ena returns to 1.
